// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master (m0 fetch, m1 data) to one-slave Wishbone classic arbiter.
// Ports: clk, reset (async, active-low); m0_wb_* / m1_wb_* master ports (cyc, stb, adr, dat, sel, we in;
// ack, dat out); s_wb_* slave port (cyc, stb, adr, dat, sel, we out; ack, dat in); grant_o one-hot owner.
// m1 has priority; a saturating streak counter hands the bus to a waiting m0 after MAX_STREAK m1 tenures.
module wb_arbiter_2m #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_wb_cyc_i,
  input  logic                    m0_wb_stb_i,
  output logic                    m0_wb_ack_o,
  input  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wb_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_wb_dat_o,
  input  logic [DATA_WIDTH/8-1:0] m0_wb_sel_i,
  input  logic                    m0_wb_we_i,
  input  logic                    m1_wb_cyc_i,
  input  logic                    m1_wb_stb_i,
  output logic                    m1_wb_ack_o,
  input  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wb_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_wb_dat_o,
  input  logic [DATA_WIDTH/8-1:0] m1_wb_sel_i,
  input  logic                    m1_wb_we_i,
  output logic                    s_wb_cyc_o,
  output logic                    s_wb_stb_o,
  input  logic                    s_wb_ack_i,
  output logic [ADDR_WIDTH-1:0]   s_wb_adr_o,
  output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   s_wb_dat_i,
  output logic [DATA_WIDTH/8-1:0] s_wb_sel_o,
  output logic                    s_wb_we_o,
  output logic [1:0]              grant_o
);
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_STREAK);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state, state_nx;
  logic [SW-1:0] streak, streak_nx;
  logic decide, pick0, pick1, own0, own1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_nx;
      streak <= streak_nx;
    end
  // A decision is only taken when nobody holds the bus: idle, or the owner's release cycle.
  always_comb begin
    decide    = state == IDLE || (state == OWN0 && !m0_wb_cyc_i) || (state == OWN1 && !m1_wb_cyc_i);
    pick1     = m1_wb_cyc_i && (!m0_wb_cyc_i || streak < MAX_S);
    pick0     = !pick1 && m0_wb_cyc_i;
    state_nx  = !decide ? state : pick1 ? OWN1 : pick0 ? OWN0 : IDLE;
    // Only an m1 grant that made m0 wait counts towards the streak; any other grant clears it.
    streak_nx = !decide ? streak
              : (pick1 && m0_wb_cyc_i) ? (streak == MAX_S ? streak : streak + SW'(1))
              : (pick1 || pick0) ? '0 : streak;
  end
  always_comb begin
    own0        = state == OWN0;
    own1        = state == OWN1;
    grant_o     = {own1, own0};
    s_wb_cyc_o  = (own0 && m0_wb_cyc_i) || (own1 && m1_wb_cyc_i);
    s_wb_stb_o  = (own0 && m0_wb_stb_i) || (own1 && m1_wb_stb_i);
    s_wb_we_o   = (own0 && m0_wb_we_i) || (own1 && m1_wb_we_i);
    s_wb_adr_o  = own0 ? m0_wb_adr_i : own1 ? m1_wb_adr_i : '0;
    s_wb_dat_o  = own0 ? m0_wb_dat_i : own1 ? m1_wb_dat_i : '0;
    s_wb_sel_o  = own0 ? m0_wb_sel_i : own1 ? m1_wb_sel_i : '0;
    m0_wb_ack_o = s_wb_ack_i && own0 && m0_wb_stb_i;
    m1_wb_ack_o = s_wb_ack_i && own1 && m1_wb_stb_i;
    m0_wb_dat_o = s_wb_dat_i;
    m1_wb_dat_o = s_wb_dat_i;
  end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed bench for wb_arbiter_2m with hand-computed expectations.
module tb_wb_arbiter_2m;
  logic        clk = 0, reset = 0;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0, m0_ack;
  logic [31:0] m0_adr = 0, m0_wdat = 0, m0_rdat;
  logic [3:0]  m0_sel = 0;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0, m1_ack;
  logic [31:0] m1_adr = 0, m1_wdat = 0, m1_rdat;
  logic [3:0]  m1_sel = 0;
  logic        s_cyc, s_stb, s_we, s_ack = 0;
  logic [31:0] s_adr, s_wdat, s_rdat = 0;
  logic [3:0]  s_sel;
  logic [1:0]  grant;
  int n_cmp = 0, n_bad = 0;

  wb_arbiter_2m #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_ack_o(m0_ack), .m0_wb_adr_i(m0_adr),
    .m0_wb_dat_i(m0_wdat), .m0_wb_dat_o(m0_rdat), .m0_wb_sel_i(m0_sel), .m0_wb_we_i(m0_we),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_ack_o(m1_ack), .m1_wb_adr_i(m1_adr),
    .m1_wb_dat_i(m1_wdat), .m1_wb_dat_o(m1_rdat), .m1_wb_sel_i(m1_sel), .m1_wb_we_i(m1_we),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_ack_i(s_ack), .s_wb_adr_o(s_adr),
    .s_wb_dat_o(s_wdat), .s_wb_dat_i(s_rdat), .s_wb_sel_o(s_sel), .s_wb_we_o(s_we),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Moves to 2 time units after the next rising edge; inputs are driven there, checks follow #1 later.
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #3;
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_grant", grant, 0);
    chk("rst_acks", {m0_ack, m1_ack}, 0);
    nxt();
    reset = 1;
    // 1: m0 read alone
    nxt();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h8000_0000; m0_sel = 4'hF;
    #1 chk("t1_t0_s_cyc", s_cyc, 0);
    nxt();
    #1 chk("t1_grant", grant, 2'b01);
    chk("t1_s_cyc", s_cyc, 1);
    chk("t1_s_adr", s_adr, 32'h8000_0000);
    chk("t1_no_early_ack", m0_ack, 0);
    nxt();
    s_ack = 1; s_rdat = 32'h0010_0093;
    #1 chk("t1_m0_ack", m0_ack, 1);
    chk("t1_m0_dat", m0_rdat, 32'h0010_0093);
    chk("t1_m1_ack", m1_ack, 0);
    nxt();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1 chk("t1_release_grant", grant, 2'b01);
    chk("t1_release_s_cyc", s_cyc, 0);
    nxt();
    #1 chk("t1_idle", grant, 2'b00);
    // 2: simultaneous requests, m1 write wins
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h8000_0004;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h8040_0000; m1_wdat = 32'hDEAD_BEEF; m1_sel = 4'hF;
    nxt();
    #1 chk("t2_grant", grant, 2'b10);
    chk("t2_s_we", s_we, 1);
    chk("t2_s_dat", s_wdat, 32'hDEAD_BEEF);
    chk("t2_s_adr", s_adr, 32'h8040_0000);
    chk("t2_s_sel", s_sel, 4'hF);
    nxt();
    s_ack = 1;
    #1 chk("t2_m1_ack", m1_ack, 1);
    chk("t2_m0_ack", m0_ack, 0);
    nxt();
    s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    #1 chk("t2_release_grant", grant, 2'b10);
    nxt();
    #1 chk("t2_m0_grant", grant, 2'b01);
    chk("t2_m0_adr", s_adr, 32'h8000_0004);
    chk("t2_m0_we", s_we, 0);
    nxt();
    m0_cyc = 0; m0_stb = 0;
    nxt();
    #1 chk("t2_idle", grant, 2'b00);
    // 3: four m1 tenures while m0 keeps asking in every idle decision, then m0 gets through
    for (int k = 0; k < 4; k++) begin
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      #1 chk("t3_idle_grant", grant, 2'b00);
      chk("t3_idle_s_adr", s_adr, 0);
      nxt();
      #1 chk("t3_m1_tenure", grant, 2'b10);
      nxt();
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      nxt();
    end
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    #1 chk("t3_idle5", grant, 2'b00);
    nxt();
    #1 chk("t3_m0_after_streak", grant, 2'b01);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    nxt();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    #1 chk("t3_idle6", grant, 2'b00);
    nxt();
    #1 chk("t3_streak_cleared", grant, 2'b10);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    nxt();
    // 4: m0 locks the bus for 3 beats while m1 requests and toggles
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h8000_0100;
    #1 chk("t4_idle", grant, 2'b00);
    nxt();
    m1_cyc = 1; m1_stb = 1; s_ack = 1;
    for (int b = 0; b < 3; b++) begin
      #1 chk("t4_grant", grant, 2'b01);
      chk("t4_m0_ack", m0_ack, 1);
      chk("t4_m1_ack", m1_ack, 0);
      chk("t4_s_adr", s_adr, 32'h8000_0100);
      nxt();
      m1_cyc = b[0]; m1_stb = b[0];
    end
    s_ack = 0; m0_cyc = 0; m0_stb = 0; m1_cyc = 1; m1_stb = 1;
    #1 chk("t4_release", grant, 2'b01);
    nxt();
    #1 chk("t4_m1_next", grant, 2'b10);
    // 5: async reset while m1 owns with stb and ack high
    s_ack = 1;
    #1 chk("t5_pre_ack", m1_ack, 1);
    reset = 0;
    #1 chk("t5_s_cyc", s_cyc, 0);
    chk("t5_s_stb", s_stb, 0);
    chk("t5_grant", grant, 2'b00);
    chk("t5_m1_ack", m1_ack, 0);
    nxt();
    s_ack = 0;
    #1 chk("t5_held", grant, 2'b00);
    reset = 1;
    #1 chk("t5_after_release", grant, 2'b00);
    nxt();
    #1 chk("t5_rearb", grant, 2'b10);
    // 6: m1 drops cyc in its ack cycle while m0 waits
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h8000_0200;
    nxt();
    s_ack = 1; m1_cyc = 0;
    #1 chk("t6_m1_ack", m1_ack, 1);
    chk("t6_m0_ack", m0_ack, 0);
    chk("t6_grant", grant, 2'b10);
    nxt();
    s_ack = 0; m1_stb = 0;
    #1 chk("t6_handover", grant, 2'b01);
    chk("t6_no_ack", {m0_ack, m1_ack}, 0);
    chk("t6_s_adr", s_adr, 32'h8000_0200);
    nxt();
    s_ack = 1;
    #1 chk("t6_m0_ack2", m0_ack, 1);
    nxt();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    nxt();
    #1 chk("t6_idle", grant, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
